bitfield_unpacker: RTL and testbench

Serializing field reader for ascending-ordered vectors such as `[0:7]`. It accepts one packed word over a valid/ready handshake and emits it as a sequence of fixed-width sub-fields, starting at the lowest-index (most significant) bit. Each field is right-aligned and zero-extended. It is the read-side counterpart to the part-select writes used throughout the register-assignment tests, and it sits between a word source and a narrower field consumer.

---
 rtl/bitfield_unpacker.sv | 99 +++++++++
 tb/tb_bitfield_unpacker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitfield_unpacker.sv
// bitfield_unpacker: takes one ascending-indexed word over valid/ready and
// emits it as NF right-aligned, zero-padded fields, lowest index first.
// Ports: clk, rst_n (async, active low)
//        in_valid/in_ready/in_data [0:WIDTH-1]   word input, bit 0 is MSB
//        out_valid/out_ready/out_field/out_index/out_last   field output
module bitfield_unpacker #(
  parameter int WIDTH = 8,
  parameter int FW    = 4,
  localparam int NF   = (WIDTH + FW - 1) / FW,
  localparam int IW   = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FW-1:0]    out_field,
  output logic [IW-1:0]    out_index,
  output logic             out_last
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q;
  logic [0:WIDTH-1]   word_q;
  logic [IW-1:0]      k_q;
  logic [IW-1:0]      nk;
  logic [FW-1:0]      fld0_in;
  logic [FW-1:0]      fld_w [NF];

  // Word bit i of field k lands at out_field[hi - i], hi being the last
  // word bit the field covers; this also right-aligns a short last field.
  // Bits beyond the word stay 0 so padding never carries x.
  function automatic logic [FW-1:0] field_at(
    input logic [0:WIDTH-1] w,
    input int               k
  );
    logic [FW-1:0] f;
    int            lo;
    int            hi;
    f  = '0;
    lo = k * FW;
    hi = (lo + FW - 1 < WIDTH) ? lo + FW - 1 : WIDTH - 1;
    for (int j = 0; j < FW; j++) begin
      if (lo + j < WIDTH) f[hi - (lo + j)] = w[lo + j];
    end
    return f;
  endfunction

  assign fld0_in = field_at(in_data, 0);

  for (genvar g = 0; g < NF; g++) begin : g_fld
    assign fld_w[g] = field_at(word_q, g);
  end

  assign nk        = k_q + IW'(1);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      k_q       <= '0;
      out_field <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q   <= EMIT;
            word_q    <= in_data;
            k_q       <= '0;
            out_field <= fld0_in;
            out_index <= '0;
            out_last  <= (NF == 1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (k_q == IW'(NF - 1)) begin
              state_q <= IDLE;
            end else begin
              k_q       <= nk;
              out_field <= fld_w[nk];
              out_index <= nk;
              out_last  <= (nk == IW'(NF - 1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitfield_unpacker.sv
// tb_bitfield_unpacker: directed table-driven bench for bitfield_unpacker.
// Covers 8/4, 8/3 (partial last field) and 4/4 (single field) configurations.
module tb_bitfield_unpacker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 8/4 instance
  logic       a_iv, a_ir, a_ov, a_or, a_last;
  logic [0:7] a_d;
  logic [3:0] a_f;
  logic [0:0] a_k;
  // 8/3 instance
  logic       b_iv, b_ir, b_ov, b_or, b_last;
  logic [0:7] b_d;
  logic [2:0] b_f;
  logic [1:0] b_k;
  // 4/4 instance
  logic       c_iv, c_ir, c_ov, c_or, c_last;
  logic [0:3] c_d;
  logic [3:0] c_f;
  logic [0:0] c_k;

  bitfield_unpacker #(.WIDTH(8), .FW(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_or), .out_field(a_f),
    .out_index(a_k), .out_last(a_last)
  );

  bitfield_unpacker #(.WIDTH(8), .FW(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_or), .out_field(b_f),
    .out_index(b_k), .out_last(b_last)
  );

  bitfield_unpacker #(.WIDTH(4), .FW(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
    .out_valid(c_ov), .out_ready(c_or), .out_field(c_f),
    .out_index(c_k), .out_last(c_last)
  );

  typedef struct {
    logic [0:7] d;
    logic [3:0] f0;
    logic [3:0] f1;
  } va_t;

  typedef struct {
    logic [0:7] d;
    logic [2:0] f0;
    logic [2:0] f1;
    logic [2:0] f2;
  } vb_t;

  va_t va [4];
  vb_t vb [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_a_rst(input string nm);
    chk({nm, "_ir"}, 32'(a_ir), 32'd1);
    chk({nm, "_ov"}, 32'(a_ov), 32'd0);
    chk({nm, "_f"}, 32'(a_f), 32'd0);
    chk({nm, "_k"}, 32'(a_k), 32'd0);
    chk({nm, "_last"}, 32'(a_last), 32'd0);
  endtask

  // Called at a negedge: word accepted on the next posedge.
  task automatic send_a(input logic [0:7] d, input logic [3:0] e0,
                        input logic [3:0] e1);
    a_iv = 1'b1;
    a_d  = d;
    a_or = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    chk("a_f0_ov", 32'(a_ov), 32'd1);
    chk("a_f0_ir", 32'(a_ir), 32'd0);
    chk("a_f0", 32'(a_f), 32'(e0));
    chk("a_f0_k", 32'(a_k), 32'd0);
    chk("a_f0_last", 32'(a_last), 32'd0);
    @(negedge clk);
    chk("a_f1_ov", 32'(a_ov), 32'd1);
    chk("a_f1", 32'(a_f), 32'(e1));
    chk("a_f1_k", 32'(a_k), 32'd1);
    chk("a_f1_last", 32'(a_last), 32'd1);
    @(negedge clk);
    chk("a_idle_ir", 32'(a_ir), 32'd1);
    chk("a_idle_ov", 32'(a_ov), 32'd0);
  endtask

  task automatic send_b(input logic [0:7] d, input logic [2:0] e0,
                        input logic [2:0] e1, input logic [2:0] e2);
    b_iv = 1'b1;
    b_d  = d;
    b_or = 1'b1;
    @(negedge clk);
    b_iv = 1'b0;
    chk("b_f0_ov", 32'(b_ov), 32'd1);
    chk("b_f0", 32'(b_f), 32'(e0));
    chk("b_f0_k", 32'(b_k), 32'd0);
    chk("b_f0_last", 32'(b_last), 32'd0);
    @(negedge clk);
    chk("b_f1", 32'(b_f), 32'(e1));
    chk("b_f1_k", 32'(b_k), 32'd1);
    chk("b_f1_last", 32'(b_last), 32'd0);
    @(negedge clk);
    chk("b_f2_ov", 32'(b_ov), 32'd1);
    chk("b_f2", 32'(b_f), 32'(e2));
    chk("b_f2_pad", 32'(b_f[2]), 32'd0);
    chk("b_f2_k", 32'(b_k), 32'd2);
    chk("b_f2_last", 32'(b_last), 32'd1);
    @(negedge clk);
    chk("b_idle_ir", 32'(b_ir), 32'd1);
    chk("b_idle_ov", 32'(b_ov), 32'd0);
  endtask

  logic [0:7] xd;

  initial begin
    va[0] = '{8'h92, 4'h9, 4'h2};
    va[1] = '{8'h3c, 4'h3, 4'hc};
    va[2] = '{8'hf0, 4'hf, 4'h0};
    va[3] = '{8'ha5, 4'ha, 4'h5};
    vb[0] = '{8'h99, 3'b100, 3'b110, 3'b001};
    vb[1] = '{8'hff, 3'b111, 3'b111, 3'b011};
    vb[2] = '{8'h5a, 3'b010, 3'b110, 3'b010};
    vb[3] = '{8'hc3, 3'b110, 3'b000, 3'b011};

    rst_n = 1'b0;
    a_iv = 1'b1; a_or = 1'b1; a_d = 8'hff;
    b_iv = 1'b0; b_or = 1'b1; b_d = 8'h00;
    c_iv = 1'b0; c_or = 1'b1; c_d = 4'h0;

    // Reset held with a word offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_a_rst("rst");
    end

    // Release with in_valid high: accepted on the first edge.
    rst_n = 1'b1;
    send_a(8'b1001_0010, 4'h9, 4'h2);

    for (int i = 0; i < 4; i++) send_a(va[i].d, va[i].f0, va[i].f1);
    for (int i = 0; i < 4; i++)
      send_b(vb[i].d, vb[i].f0, vb[i].f1, vb[i].f2);

    // Unknown bits must pass straight through; padding must stay 0.
    xd = 8'hxx;
    send_b(xd, {xd[0], xd[1], xd[2]}, {xd[3], xd[4], xd[5]},
           {1'b0, xd[6], xd[7]});

    // Single-field word.
    c_iv = 1'b1;
    c_d  = 4'ha;
    @(negedge clk);
    c_iv = 1'b0;
    chk("c_ov", 32'(c_ov), 32'd1);
    chk("c_f", 32'(c_f), 32'ha);
    chk("c_k", 32'(c_k), 32'd0);
    chk("c_last", 32'(c_last), 32'd1);
    @(negedge clk);
    chk("c_idle_ir", 32'(c_ir), 32'd1);
    chk("c_idle_ov", 32'(c_ov), 32'd0);

    // Backpressure on field 0 with junk words offered meanwhile.
    a_iv = 1'b1;
    a_d  = 8'h9e;
    @(negedge clk);
    a_or = 1'b0;
    a_d  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      a_iv = (i % 2 == 0);
      chk("bp_f", 32'(a_f), 32'h9);
      chk("bp_ov", 32'(a_ov), 32'd1);
      chk("bp_ir", 32'(a_ir), 32'd0);
      chk("bp_k", 32'(a_k), 32'd0);
      @(negedge clk);
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    chk("bp_rel_f0", 32'(a_f), 32'h9);
    chk("bp_rel_ov0", 32'(a_ov), 32'd1);
    @(negedge clk);
    chk("bp_rel_f1", 32'(a_f), 32'he);
    chk("bp_rel_k1", 32'(a_k), 32'd1);
    chk("bp_rel_last", 32'(a_last), 32'd1);
    @(negedge clk);
    chk("bp_idle_ov", 32'(a_ov), 32'd0);
    chk("bp_idle_ir", 32'(a_ir), 32'd1);
    @(negedge clk);
    chk("bp_idle2_ov", 32'(a_ov), 32'd0);

    // Reset mid-word.
    a_iv = 1'b1;
    a_d  = 8'h3e;
    @(negedge clk);
    a_iv = 1'b0;
    chk("mr_f0", 32'(a_f), 32'h3);
    rst_n = 1'b0;
    #1;
    chk_a_rst("mr_async");
    @(negedge clk);
    chk_a_rst("mr_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_ov", 32'(a_ov), 32'd0);
    chk("mr_post_ir", 32'(a_ir), 32'd1);
    send_a(8'h66, 4'h6, 4'h6);
    @(negedge clk);
    chk("mr_end_ov", 32'(a_ov), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
